// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: programmable UART oversample/bit tick generator; BAUD_FRAC_EN adds the fractional divider.
module uart_baud_gen_frac #(
  parameter int CLK_FPGA = 50000000,
  parameter int BAUDRATE = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  localparam int PH_W = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_pending,
  output logic              tick_os,
  output logic              tick_bit,
  output logic [PH_W-1:0]   tick_phase
);
  localparam longint DEN = longint'(BAUDRATE) * longint'(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(longint'(CLK_FPGA) / DEN);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  logic [DIV_W-1:0] div, div_sh;
  logic [DIV_W:0]   cnt, per;
  logic [PH_W-1:0]  phase;
  logic             carry_in, term, upd;
  assign upd = cfg_load | cfg_pending;
  assign per = {1'b0, ((div < DIV_W'(2)) ? DIV_W'(2) : div)} + {{DIV_W{1'b0}}, carry_in};
  assign term = cnt == per - 1'b1;
  assign tick_phase = phase;
  // a new divisor only lands on a period boundary or while idle, so spacing never glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div         <= DIV_RST;
      div_sh      <= DIV_RST;
      cnt         <= '0;
      phase       <= '0;
      cfg_pending <= 1'b0;
      tick_os     <= 1'b0;
      tick_bit    <= 1'b0;
    end else begin
      if (cfg_load) div_sh <= cfg_div;
      if ((!en || term) && upd) div <= cfg_load ? cfg_div : div_sh;
      cnt         <= (!en || term) ? '0 : cnt + 1'b1;
      tick_os     <= en && term;
      tick_bit    <= en && term && phase == PH_LAST;
      phase       <= !en ? '0 : !term ? phase : (phase == PH_LAST) ? '0 : phase + 1'b1;
      cfg_pending <= (!en || term) ? 1'b0 : upd;
    end
`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'((longint'(CLK_FPGA) << FRAC_W) / DEN);
  logic [FRAC_W-1:0] frac, frac_sh, acc;
  logic              carry;
  assign carry_in = carry;
  // the accumulator overflow stretches the following period by one clock
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frac    <= FRAC_RST;
      frac_sh <= FRAC_RST;
      acc     <= '0;
      carry   <= 1'b0;
    end else begin
      if (cfg_load) frac_sh <= cfg_frac;
      if ((!en || term) && upd) frac <= cfg_load ? cfg_frac : frac_sh;
      if (!en || (term && upd)) {carry, acc} <= '0;
      else if (term) {carry, acc} <= {1'b0, acc} + {1'b0, frac};
    end
`else
  logic unused_frac;
  assign carry_in = 1'b0;
  assign unused_frac = ^cfg_frac;
`endif
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: directed scenarios plus random traffic against a tick-schedule reference model.
module tb_uart_baud_gen_frac;
  logic clk = 1'b0, rst, en, cfg_load;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_frac;
  logic        cfg_pending, tick_os, tick_bit;
  logic [3:0]  tick_phase;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  int     n_tests = 0, n_fail = 0;
  longint md, mf, sd, sf, t, n, cyc, tick_cnt, last_tick, prev_tick;
  int     pend, ph, m_tos, m_tbit;

  uart_baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_div(cfg_div), .cfg_frac(cfg_frac),
    .cfg_pending(cfg_pending), .tick_os(tick_os), .tick_bit(tick_bit), .tick_phase(tick_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    md = 325; mf = 8; sd = 325; sf = 8;
    pend = 0; t = 0; n = 0; ph = 0; m_tos = 0; m_tbit = 0;
  endtask

  // tick k of a segment lands k*D + floor((k-1)*F/16) RUN edges after the segment starts
  task automatic model_edge(input bit e, input bit ld, input longint d, input longint f);
    longint deff, fe;
    bit hit;
    if (!e) begin
      t = 0; n = 0; ph = 0; m_tos = 0; m_tbit = 0;
      if (ld) begin md = d; mf = f; end
      else if (pend != 0) begin md = sd; mf = sf; end
      pend = 0;
    end else begin
      t++;
      deff = (md < 2) ? 2 : md;
      fe = FRAC_ON ? mf : 0;
      hit = (t == (n + 1) * deff + ((n * fe) / 16));
      m_tos = int'(hit);
      m_tbit = int'(hit && ph == 15);
      if (hit) begin
        ph = (ph + 1) % 16;
        n++;
        if (ld || pend != 0) begin
          if (ld) begin md = d; mf = f; end
          else begin md = sd; mf = sf; end
          t = 0; n = 0; pend = 0;
        end
      end else if (ld) begin
        sd = d; sf = f; pend = 1;
      end
    end
  endtask

  task automatic step(input bit e, input bit ld, input longint d, input longint f);
    en = e; cfg_load = ld; cfg_div = 16'(d); cfg_frac = 4'(f);
    @(posedge clk);
    model_edge(e, ld, d, f);
    cyc++;
    #1;
    check("tick_os", tick_os, m_tos);
    check("tick_bit", tick_bit, m_tbit);
    check("tick_phase", tick_phase, ph);
    check("cfg_pending", cfg_pending, pend);
    if (tick_os) begin
      tick_cnt++;
      prev_tick = last_tick;
      last_tick = cyc;
    end
    cfg_load = 1'b0;
  endtask

  task automatic run_until_tick(input bit e, input int max);
    int k = 0;
    longint c = tick_cnt;
    while (tick_cnt == c && k < max) begin
      step(e, 1'b0, 0, 0);
      k++;
    end
    if (tick_cnt == c) check("tick_timeout", 0, 1);
  endtask

  initial begin
    longint t1 = 0, t161 = 0, b1 = 0, b2 = 0, c0;
    bit e;
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_frac = '0;
    cyc = 0; tick_cnt = 0; last_tick = 0; prev_tick = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick_os", tick_os, 0);
    check("rst_tick_bit", tick_bit, 0);
    check("rst_phase", tick_phase, 0);
    check("rst_pending", cfg_pending, 0);
    rst = 1'b0;

    // default divisor: first tick latency, 160-period span, bit tick spacing
    while (tick_cnt < 161 && cyc < 60000) begin
      step(1'b1, 1'b0, 0, 0);
      if (tick_os && tick_cnt == 1) t1 = cyc;
      if (tick_os && tick_cnt == 161) t161 = cyc;
      if (tick_bit) begin
        if (b1 == 0) b1 = cyc;
        else if (b2 == 0) b2 = cyc;
      end
    end
    check("first_tick", t1, 325);
    check("span_161", t161 - t1, FRAC_ON ? 52080 : 52000);
    check("bit_spacing", b2 - b1, FRAC_ON ? 5208 : 5200);

    // mid-period reload waits for the current period to finish
    repeat (100) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 27, 0);
    check("load_pending", cfg_pending, 1);
    run_until_tick(1'b1, 400);
    check("pending_cleared", cfg_pending, 0);
    run_until_tick(1'b1, 400);
    check("spacing_27", last_tick - prev_tick, 27);

    // reload on the terminal edge itself, with D=1 clamped to 2
    repeat (26) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1, 0);
    check("term_load_tick", tick_os, 1);
    check("term_load_pending", cfg_pending, 0);
    run_until_tick(1'b1, 10);
    check("spacing_d1", last_tick - prev_tick, 2);
    step(1'b1, 1'b1, 0, 0);
    run_until_tick(1'b1, 10);
    run_until_tick(1'b1, 10);
    check("spacing_d0", last_tick - prev_tick, 2);

    // enable drop after 7 ticks, then re-enable
    step(1'b1, 1'b1, 5, 0);
    repeat (7) run_until_tick(1'b1, 20);
    repeat (10) step(1'b0, 1'b0, 0, 0);
    check("idle_phase", tick_phase, 0);
    c0 = cyc;
    run_until_tick(1'b1, 20);
    check("reenable_latency", last_tick - c0, 5);

    // async reset with a load pending
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 9, 3);
    check("pre_rst_pending", cfg_pending, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_tick_os", tick_os, 0);
    check("async_phase", tick_phase, 0);
    check("async_pending", cfg_pending, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    run_until_tick(1'b1, 400);
    check("post_rst_first_tick", last_tick, 325);
    check("post_rst_pending", cfg_pending, 0);

    // random traffic
    e = 1'b1;
    step(1'b1, 1'b1, 7, 5);
    repeat (4000) begin
      if ($urandom_range(0, 79) == 0) e = ~e;
      if ($urandom_range(0, 24) == 0)
        step(e, 1'b1, longint'($urandom_range(0, 24)), longint'($urandom_range(0, 15)));
      else
        step(e, 1'b0, longint'($urandom_range(0, 24)), longint'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
